gate_bist_ctrl: RTL
===================

Name: gate_bist_ctrl

Overview:
- Sequential checker that sits at the stimulus/response boundary of the two-input gate bank.
- Drives the four {A,B} patterns into the gate bank, waits a settle window, then samples its eight outputs.
- Compares the samples against an internal golden truth table and reports pass/fail plus per-output failure flags.
- Provides in-silicon self-test of the gate bank; no simulator stimulus required.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a pattern and sampling dut_out; legal 0..255.
- NUM_PASSES, 1, full four-pattern sweeps per run; legal 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run.
- a_out  output  1  A stimulus to the gate bank.
- b_out  output  1  B stimulus to the gate bank.
- dut_out  input  8  gate bank outputs. Bit order: 0 AND, 1 OR, 2 NOT(~A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUFFER(A).
- busy  output  1  high from APPLY through the last CHECK.
- done  output  1  high while in DONE.
- pass  output  1  valid when done=1; 1 means no mismatch was seen.
- fail_vec  output  8  sticky per-bit mismatch flags for the current run.
- fail_count  output  8  count of pattern checks with at least one mismatch; saturates at 255.
- first_fail_pat  output  2  {A,B} of the first failing check; valid when first_fail_valid=1.
- first_fail_valid  output  1  set on the first mismatch of the run.

Behaviour:
- Reset (async, immediate, also mid-run):
  - state=IDLE; a_out=b_out=0; busy=done=pass=0; fail_vec=0; fail_count=0; first_fail_pat=0; first_fail_valid=0.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> APPLY on the sampling edge (edge 0).
  - On the same edge: clear all result registers, set pattern index=0, pass counter=0, and register a_out/b_out = pattern 0.
- APPLY: one cycle. Go to SETTLE if SETTLE_CYCLES>0, otherwise to CHECK.
- SETTLE: exactly SETTLE_CYCLES cycles, then CHECK.
- CHECK: one cycle.
  - Compare dut_out with golden(a_out,b_out); mismatch = dut_out XOR golden.
  - fail_vec |= mismatch.
  - If mismatch is nonzero: fail_count += 1 (saturating).
  - If mismatch is nonzero and first_fail_valid=0: latch first_fail_pat={a_out,b_out} and set first_fail_valid.
  - Pattern order 00,01,10,11, with index = {A,B}.
  - If index<3: index++, drive the next pattern on a_out/b_out on the same edge, go to APPLY.
  - If index=3 and passes remain: index=0, pattern 00, go to APPLY.
  - Otherwise go to DONE.
- Golden values:
  - AND=A&B, OR=A|B, NOT=~A, NAND=~(A&B), NOR=~(A|B), XOR=A^B, XNOR=~(A^B), BUFFER=A.
- Timing:
  - Each pattern occupies SETTLE_CYCLES+2 cycles.
  - done rises at edge 4*(SETTLE_CYCLES+2)*NUM_PASSES after the start edge (default: edge 16).
- DONE:
  - done=1, busy=0; pass=(fail_vec==0).
  - Results hold until the next start.
  - start in DONE begins a new run exactly as from IDLE.
- start while busy is ignored.
- a_out/b_out are registered and hold the last pattern (11) in DONE; they return to 0 only on reset.

Optional Feature:
- Macro: GATE_BIST_FAULT_INJ_EN.
- Defined:
  - Adds input inj_en (1 bit) and input inj_mask (8 bits).
  - In CHECK, when inj_en=1, the compared value is dut_out XOR inj_mask, so a known-good bank can exercise the failure path.
- Undefined:
  - Both ports are absent; dut_out is compared directly.
  - Behaviour is otherwise identical.

Test Plan:
- Correct gate model, defaults, start pulse at edge 0 -> a_out/b_out step through 00,01,10,11 every 4 cycles; done=1 at edge 16; pass=1; fail_vec=8'h00; fail_count=0; first_fail_valid=0.
- XOR output stuck at 0 -> fail_vec=8'h20; fail_count=2; first_fail_pat=2'b01; pass=0.
- NOT output stuck at 1, NUM_PASSES=2 -> fail_vec=8'h04; fail_count=4 (patterns 10,11 in each pass); first_fail_pat=2'b10; done at edge 32.
- SETTLE_CYCLES=0 -> APPLY goes directly to CHECK; done at edge 8; start pulses during busy cause no restart.
- Async rst asserted at edge 6 mid-run -> all outputs zero immediately, state IDLE; a later start runs cleanly to pass=1.
- GATE_BIST_FAULT_INJ_EN with good model, inj_en=1, inj_mask=8'h81 -> fail_vec=8'h81; fail_count=4; first_fail_pat=2'b00.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for the two-input gate bank: applies 00,01,10,11, compares against golden.
// Optional fault-injection ports (inj_en, inj_mask) are enabled by defining GATE_BIST_FAULT_INJ_EN.
module gate_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef GATE_BIST_FAULT_INJ_EN
   input  logic       inj_en,
   input  logic [7:0] inj_mask,
`endif
   input  logic [7:0] dut_out,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_vec,
   output logic [7:0] fail_count,
   output logic [1:0] first_fail_pat,
   output logic       first_fail_valid
);

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

   localparam logic [7:0] LP_SETTLE = 8'(SETTLE_CYCLES);
   localparam logic [7:0] LP_PASSES = 8'(NUM_PASSES);

   // Bit order: BUF, XNOR, XOR, NOR, NAND, NOT, OR, AND (MSB..LSB)
   function automatic logic [7:0] golden(input logic a, input logic b);
      golden = {a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
   endfunction

   state_t     r_state, w_state;
   logic       r_a, r_b, w_a, w_b;
   logic [7:0] r_settle_cnt, w_settle_cnt;
   logic [7:0] r_pass_cnt, w_pass_cnt;
   logic       r_busy, w_busy, r_done, w_done, r_pass, w_pass;
   logic [7:0] r_fail_vec, w_fail_vec, r_fail_count, w_fail_count;
   logic [1:0] r_ffp, w_ffp;
   logic       r_ffv, w_ffv;
   logic [7:0] w_cmp, w_mism, w_vec_acc;

`ifdef GATE_BIST_FAULT_INJ_EN
   assign w_cmp = inj_en ? (dut_out ^ inj_mask) : dut_out;
`else
   assign w_cmp = dut_out;
`endif
   assign w_mism    = w_cmp ^ golden(r_a, r_b);
   assign w_vec_acc = r_fail_vec | w_mism;

   // Next-state and next-result computation
   always_comb begin
      w_state      = r_state;
      w_a          = r_a;
      w_b          = r_b;
      w_settle_cnt = r_settle_cnt;
      w_pass_cnt   = r_pass_cnt;
      w_busy       = r_busy;
      w_done       = r_done;
      w_pass       = r_pass;
      w_fail_vec   = r_fail_vec;
      w_fail_count = r_fail_count;
      w_ffp        = r_ffp;
      w_ffv        = r_ffv;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state      = S_APPLY;
               {w_a, w_b}   = 2'b00;
               w_settle_cnt = 8'd0;
               w_pass_cnt   = 8'd0;
               w_busy       = 1'b1;
               w_done       = 1'b0;
               w_pass       = 1'b0;
               w_fail_vec   = 8'd0;
               w_fail_count = 8'd0;
               w_ffp        = 2'b00;
               w_ffv        = 1'b0;
            end else begin
               w_state = r_state;
            end
         end
         S_APPLY: begin
            w_settle_cnt = 8'd0;
            if (LP_SETTLE != 8'd0) w_state = S_SETTLE;
            else                   w_state = S_CHECK;
         end
         S_SETTLE: begin
            if (r_settle_cnt == LP_SETTLE - 8'd1) w_state = S_CHECK;
            else                                   w_settle_cnt = r_settle_cnt + 8'd1;
         end
         S_CHECK: begin
            w_fail_vec = w_vec_acc;
            if (w_mism != 8'd0) begin
               if (r_fail_count != 8'hFF) w_fail_count = r_fail_count + 8'd1;
               else                       w_fail_count = r_fail_count;
               if (!r_ffv) begin
                  w_ffp = {r_a, r_b};
                  w_ffv = 1'b1;
               end else begin
                  w_ffp = r_ffp;
               end
            end else begin
               w_fail_count = r_fail_count;
            end
            // Pattern index is {A,B} itself, so stepping it steps the stimulus
            if ({r_a, r_b} != 2'b11) begin
               {w_a, w_b} = {r_a, r_b} + 2'd1;
               w_state    = S_APPLY;
            end else if (r_pass_cnt != LP_PASSES - 8'd1) begin
               {w_a, w_b} = 2'b00;
               w_pass_cnt = r_pass_cnt + 8'd1;
               w_state    = S_APPLY;
            end else begin
               w_state = S_DONE;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_pass  = (w_vec_acc == 8'd0);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_a          <= 1'b0;
         r_b          <= 1'b0;
         r_settle_cnt <= 8'd0;
         r_pass_cnt   <= 8'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_vec   <= 8'd0;
         r_fail_count <= 8'd0;
         r_ffp        <= 2'b00;
         r_ffv        <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_a          <= w_a;
         r_b          <= w_b;
         r_settle_cnt <= w_settle_cnt;
         r_pass_cnt   <= w_pass_cnt;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_pass       <= w_pass;
         r_fail_vec   <= w_fail_vec;
         r_fail_count <= w_fail_count;
         r_ffp        <= w_ffp;
         r_ffv        <= w_ffv;
      end
   end

   assign a_out            = r_a;
   assign b_out            = r_b;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign fail_vec         = r_fail_vec;
   assign fail_count       = r_fail_count;
   assign first_fail_pat   = r_ffp;
   assign first_fail_valid = r_ffv;

endmodule
